// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU engine; define MUL_DIV_FAST_MUL_EN for a single-cycle multiplier
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             annul,
    output logic             stallreq,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // mul: upper partial product / div: partial remainder
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    // mul: multiplier shifting out, low product shifting in / div: dividend out, quotient in
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_prod_q, neg_prod_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               accept;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_final;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_final;
    logic [WIDTH-1:0]   quo_final;

    // Operand decode: signed ops work on magnitudes, unsigned ops on raw operands.
    always_comb begin
        is_signed = ~op[0];
        is_div    = op[1];
        sign_a    = is_signed & src_a[WIDTH-1];
        sign_b    = is_signed & src_b[WIDTH-1];
        mag_a     = sign_a ? ({WIDTH{1'b0}} - src_a) : src_a;
        mag_b     = sign_b ? ({WIDTH{1'b0}} - src_b) : src_b;
        accept    = rst & (state_q == ST_IDLE) & start & ~annul;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // One shift-add step and one restoring-divide step, plus final sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_lo_q[WIDTH-1:1]};
        mul_final = neg_prod_q ? ({(2*WIDTH){1'b0}} - mul_next) : mul_next;

        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[WIDTH]) begin
            rem_next = div_diff[WIDTH-1:0];
            quo_next = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = div_shift[WIDTH-1:0];
            quo_next = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        quo_final = neg_prod_q ? ({WIDTH{1'b0}} - quo_next) : quo_next;
        rem_final = neg_rem_q ? ({WIDTH{1'b0}} - rem_next) : rem_next;
    end

`ifdef MUL_DIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    logic [2*WIDTH-1:0] fast_final;

    // Single-cycle full-width product of the operand magnitudes.
    always_comb begin
        fast_prod  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_final = (sign_a ^ sign_b) ? ({(2*WIDTH){1'b0}} - fast_prod) : fast_prod;
    end
`endif

    // Sequencer next-state; annul dominates everything, including a same-cycle start.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (annul) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_d      = '0;
                        neg_prod_d = sign_a ^ sign_b;
                        neg_rem_d  = sign_a;
                        dbz_d      = 1'b0;
                        if (is_div) begin
                            if (src_b == '0) begin
                                state_d = ST_DONE;
                                dbz_d   = 1'b1;
                                hi_d    = src_a;
                                lo_d    = '1;
                            end else begin
                                state_d  = ST_DIV;
                                acc_hi_d = '0;
                                acc_lo_d = mag_a;
                                opnd_d   = mag_b;
                            end
                        end else begin
`ifdef MUL_DIV_FAST_MUL_EN
                            state_d      = ST_DONE;
                            {hi_d, lo_d} = fast_final;
`else
                            state_d  = ST_MUL;
                            acc_hi_d = '0;
                            acc_lo_d = mag_b;
                            opnd_d   = mag_a;
`endif
                        end
                    end
                end
                ST_MUL: begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    acc_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    acc_lo_d = mul_next[WIDTH-1:0];
                    if (last_iter) begin
                        state_d      = ST_DONE;
                        {hi_d, lo_d} = mul_final;
                    end
                end
                ST_DIV: begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    acc_hi_d = rem_next;
                    acc_lo_d = quo_next;
                    if (last_iter) begin
                        state_d = ST_DONE;
                        hi_d    = rem_final;
                        lo_d    = quo_final;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Outputs; stallreq is low in DONE so EX advances together with the result.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        stallreq     = accept | (state_q == ST_MUL) | (state_q == ST_DIV);
        result_valid = (state_q == ST_DONE) & ~annul;
        div_by_zero  = result_valid & dbz_q;
        hi           = hi_q;
        lo           = lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and randomized self-checking bench for mul_div_unit
`timescale 1ns/1ps
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MUL_DIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         annul = 1'b0;
    logic         stallreq;
    logic         busy;
    logic         result_valid;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_fail = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .annul        (annul),
        .stallreq     (stallreq),
        .busy         (busy),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    task automatic ref_calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] rh, output logic [W-1:0] rl,
                            output bit dz, output int lat);
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        dz = 1'b0;
        lat = W + 1;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin sr = sa * sb; rh = sr[63:32]; rl = sr[31:0]; lat = MUL_LAT; end
            2'b01: begin ur = ua * ub; rh = ur[63:32]; rl = ur[31:0]; lat = MUL_LAT; end
            default: begin
                if (b == '0) begin
                    rh = a; rl = '1; dz = 1'b1; lat = 1;
                end else if (o == 2'b10) begin
                    sr = sa / sb; rl = sr[31:0];
                    sr = sa % sb; rh = sr[31:0];
                end else begin
                    ur = ua / ub; rl = ur[31:0];
                    ur = ua % ub; rh = ur[31:0];
                end
            end
        endcase
    endtask

    // Behavioural model: time-stamped accept plus latency, committed result pair.
    bit           m_active = 1'b0;
    int           m_acc = 0;
    int           m_lat = 0;
    int           cyc = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    bit           p_dz = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (m_active && annul) begin
                m_active = 1'b0;
            end else if (m_active && cyc == m_acc + m_lat) begin
                m_active = 1'b0;
            end else if (!m_active && start && !annul) begin
                ref_calc(op, src_a, src_b, p_hi, p_lo, p_dz, m_lat);
                m_active = 1'b1;
                m_acc = cyc;
            end
            if (m_active && cyc + 1 == m_acc + m_lat) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            cyc++;
        end
    end

    // Every cycle: compare DUT outputs against the model.
    always @(negedge clk) begin
        bit         iter;
        bit         done;
        logic [3:0] exp_ctl;
        iter = m_active && m_lat > 1 && cyc > m_acc && cyc < m_acc + m_lat;
        done = m_active && cyc == m_acc + m_lat;
        exp_ctl = {(rst && !m_active && start && !annul) || iter,
                   iter || done,
                   done && !annul,
                   done && !annul && p_dz};
        chk("ctl", {stallreq, busy, result_valid, div_by_zero}, exp_ctl);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    // Issue one op right after a posedge; optionally pulse an ignored start at cycle t+poke_at.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input bit exp_dz, input int exp_lat,
                          input int poke_at);
        int stalls;
        bit seen;
        start = 1'b1; op = o; src_a = a; src_b = b; annul = 1'b0;
        @(negedge clk);
        chk({name, "/stall_at_t"}, stallreq, 1);
        stalls = 0;
        seen = 1'b0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(posedge clk); #1;
            start = (k == poke_at);
            if (k == poke_at) begin op = 2'b01; src_a = 3; src_b = 3; end
            @(negedge clk);
            if (result_valid) begin
                seen = 1'b1;
                chk({name, "/latency"}, k, exp_lat);
                chk({name, "/hi"}, hi, exp_hi);
                chk({name, "/lo"}, lo, exp_lo);
                chk({name, "/dbz"}, div_by_zero, exp_dz);
                chk({name, "/stall_in_done"}, stallreq, 0);
                chk({name, "/stall_cycles"}, stalls, exp_lat - 1);
            end else if (stallreq) begin
                stalls++;
            end
        end
        if (!seen) chk({name, "/timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0: pick = '0;
            1: pick = 32'h0000_0001;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'h8000_0000;
            4: pick = W'($urandom_range(15));
            default: pick = W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        bit           dz;
        int           lat;
        int           saw_valid;

        ref_calc(2'b10, 32'hFFFF_FFF9, 32'h2, rh, rl, dz, lat);
        chk("model/div_neg7_2", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
        ref_calc(2'b00, 32'hFFFF_FFFF, 32'h2, rh, rl, dz, lat);
        chk("model/mult_m1_2", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFE);

        #12;
        chk("reset/ctl", {stallreq, busy, result_valid, div_by_zero}, 0);
        chk("reset/hilo", {hi, lo}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 1, 0);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 1, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, W + 1, 0);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, 0);
        run_op("mult", 2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT, 0);
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, MUL_LAT, 0);
        run_op("divu_100_7b", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 1, 0);

        // Annul at t+10 of a DIVU: back in IDLE at t+11 with hi/lo untouched.
        start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
        saw_valid = 0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            annul = (k == 10);
            if (result_valid) saw_valid++;
        end
        chk("annul/busy", busy, 0);
        chk("annul/no_valid", saw_valid, 0);
        chk("annul/hilo", {hi, lo}, {32'd2, 32'd14});
        run_op("after_annul", 2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, W + 1, 0);

        // Asynchronous reset in the middle of a DIV.
        start = 1'b1; op = 2'b10; src_a = 32'h1234_5678; src_b = 32'h31;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("midreset/ctl", {stallreq, busy, result_valid, div_by_zero}, 0);
        chk("midreset/hilo", {hi, lo}, 0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_reset", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, W + 1, 4);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(3) == 0);
            op = 2'($urandom_range(3));
            src_a = pick();
            src_b = pick();
            annul = ($urandom_range(127) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        annul = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
